arc4_encrypt: RTL and testbench

- ARC4 encryptor: reads a length-prefixed plaintext message from pt memory and writes the length-prefixed ciphertext to ct memory.
- This is the mirror of the arc4 decryption core, which reads ct_mem and writes pt_mem.
- Its output ct memory image is directly consumable by arc4. The round-trip is arc4_encrypt then arc4, with the same key.
- Holds its own 256-byte S-box in registers; uses the same en/rdy start handshake as arc4.

---
 rtl/arc4_encrypt.sv | 133 +++++++++++++
 tb/tb_arc4_encrypt.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext from pt memory and writes the
// length-prefixed ciphertext to ct memory, using a register-based 256-byte S-box.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren
);

  typedef enum logic [3:0] {
    IDLE, INIT, KSA, RD_WAIT, RD_LEN, P_SWAP, P_WAIT, P_XOR, FLUSH, DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]             s [256];
  logic [7:0]             i, j, len;
  logic [8:0]             k;
  logic [8*KEY_BYTES-1:0] key_sh;

  logic [7:0] key_byte, j_ksa, i_p1, si_p1, j_prga, pad_idx, pad;

  // The key register rotates one byte per KSA step, so its top byte is always key[i mod KEY_BYTES].
  assign key_byte = key_sh[8*KEY_BYTES-1 -: 8];
  assign j_ksa    = j + s[i] + key_byte;
  assign i_p1     = i + 8'd1;
  assign si_p1    = s[i_p1];
  assign j_prga   = j + si_p1;
  assign pad_idx  = s[i] + s[j];
  assign pad      = s[pad_idx];
  assign rdy      = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = INIT;
      INIT:    if (i == 8'hFF) state_nxt = KSA;
      KSA:     if (i == 8'hFF) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = RD_LEN;
      RD_LEN:  state_nxt = (pt_rddata == 8'd0) ? FLUSH : P_SWAP;
      P_SWAP:  state_nxt = P_WAIT;
      P_WAIT:  state_nxt = P_XOR;
      P_XOR:   state_nxt = (k == {1'b0, len}) ? FLUSH : P_SWAP;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 9'd0;
      len       <= 8'd0;
      key_sh    <= '0;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
    end else begin
      ct_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_sh <= key;
            i      <= 8'd0;
            j      <= 8'd0;
            k      <= 9'd0;
          end
        end
        INIT: i <= i + 8'd1;
        KSA: begin
          i       <= i + 8'd1;
          j       <= (i == 8'hFF) ? 8'd0 : j_ksa;
          key_sh  <= (key_sh << 8) | (key_sh >> (8*KEY_BYTES-8));
          pt_addr <= 8'd0;
        end
        RD_LEN: begin
          len       <= pt_rddata;
          ct_addr   <= 8'd0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          k         <= 9'd1;
        end
        P_SWAP: begin
          i       <= i_p1;
          j       <= j_prga;
          pt_addr <= k[7:0];
        end
        // pt[k] arrives this cycle; pad uses the post-swap S contents.
        P_XOR: begin
          ct_addr   <= k[7:0];
          ct_wrdata <= pt_rddata ^ pad;
          ct_wren   <= 1'b1;
          k         <= k + 9'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the S-box is a memory with no reset; INIT fully rewrites it on every run.
  always_ff @(posedge clk) begin
    case (state)
      INIT: s[i] <= i;
      KSA: begin
        s[i]     <= s[j_ksa];
        s[j_ksa] <= s[i];
      end
      P_SWAP: begin
        s[i_p1]   <= s[j_prga];
        s[j_prga] <= si_p1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: behavioural RC4 model, synchronous pt memory, ct write monitor.
module tb_arc4_encrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] key;
  logic        rdy;
  logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;
  logic        ct_wren;

  int errors = 0;
  int checks = 0;

  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  int         ks [256];

  int         wr_count  = 0;
  int         wr0_count = 0;
  int         wr_bad    = 0;
  int         cur_len   = 255;
  logic       clr_req   = 1'b0;
  logic [7:0] fill_seed = 8'h00;

  always #5 clk = ~clk;

  arc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren)
  );

  function automatic logic [7:0] fill_byte(input int a);
    return 8'(a * 37) ^ fill_seed;
  endfunction

  always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

  always @(posedge clk) begin
    if (clr_req) begin
      for (int a = 0; a < 256; a++) ct_mem[a] <= fill_byte(a);
      wr_count  = 0;
      wr0_count = 0;
      wr_bad    = 0;
    end else if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wrdata;
      wr_count++;
      if (ct_addr == 8'd0) wr0_count++;
      if (int'(ct_addr) > cur_len) wr_bad++;
    end
  end

  // Plain-arithmetic RC4: KSA over the 3 key bytes, then keystream bytes ks[1..len].
  task automatic model_ks(input logic [23:0] kk, input int len);
    int sb [256];
    int kb [3];
    int ii, jj, t;
    kb[0] = int'(kk[23:16]);
    kb[1] = int'(kk[15:8]);
    kb[2] = int'(kk[7:0]);
    for (int a = 0; a < 256; a++) sb[a] = a;
    jj = 0;
    for (int a = 0; a < 256; a++) begin
      jj = (jj + sb[a] + kb[a % 3]) % 256;
      t = sb[a]; sb[a] = sb[jj]; sb[jj] = t;
    end
    ii = 0;
    jj = 0;
    for (int n = 1; n <= len; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + sb[ii]) % 256;
      t = sb[ii]; sb[ii] = sb[jj]; sb[jj] = t;
      ks[n] = sb[(sb[ii] + sb[jj]) % 256];
    end
  endtask

  task automatic build_expected(input logic [23:0] kk, input int len);
    model_ks(kk, len);
    exp_ct[0] = 8'(len);
    for (int n = 1; n <= len; n++) exp_ct[n] = pt_mem[n] ^ 8'(ks[n]);
  endtask

  task automatic fill_pt(input int len, input bit zeros);
    pt_mem[0] = 8'(len);
    for (int a = 1; a < 256; a++) pt_mem[a] = zeros ? 8'h00 : 8'($urandom_range(0, 255));
    cur_len = len;
  endtask

  task automatic clear_ct();
    fill_seed = 8'($urandom_range(0, 255));
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] kk);
    @(negedge clk);
    key = kk;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
  endtask

  // Returns the number of rising edges from the start edge until rdy is seen high.
  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 1;
    while (!rdy && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL %s_timeout: rdy still low after %0d cycles, limit %0d", name, cyc, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    key = 24'h0;
    #1;
    checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL reset_rdy got %b want 1", rdy); end
    checks++; if (ct_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", ct_wren); end
    checks++; if (pt_addr !== 8'd0) begin errors++; $display("FAIL reset_pt_addr got %02h want 00", pt_addr); end
    checks++; if (ct_addr !== 8'd0) begin errors++; $display("FAIL reset_ct_addr got %02h want 00", ct_addr); end
    checks++; if (ct_wrdata !== 8'd0) begin errors++; $display("FAIL reset_wrdata got %02h want 00", ct_wrdata); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vector();
    logic [7:0] vec_pt [10] = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] vec_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    int cyc;
    fill_pt(9, 1'b0);
    for (int a = 0; a < 10; a++) pt_mem[a] = vec_pt[a];
    clear_ct();
    start_run(24'h4B6579);
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL known_rdy_drop got %b want 0", rdy); end
    wait_done("known", 700, cyc);
    checks++; if (cyc > 580) begin errors++; $display("FAIL known_latency got %0d cycles want <= 580", cyc); end
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (ct_mem[n] !== vec_ct[n]) begin
        errors++; $display("FAIL known_ct[%0d] got %02h want %02h", n, ct_mem[n], vec_ct[n]);
      end
    end
    checks++; if (wr_count != 10) begin errors++; $display("FAIL known_writes got %0d want 10", wr_count); end
  endtask

  task automatic test_round_trip();
    logic [7:0] orig [41];
    logic [7:0] rec;
    int cyc;
    fill_pt(40, 1'b0);
    for (int a = 0; a <= 40; a++) orig[a] = pt_mem[a];
    clear_ct();
    start_run(24'h000018);
    wait_done("round_trip", 800, cyc);
    model_ks(24'h000018, int'(ct_mem[0]));
    checks++; if (ct_mem[0] !== 8'd40) begin errors++; $display("FAIL rt_len got %02h want 28", ct_mem[0]); end
    for (int n = 1; n <= 40; n++) begin
      rec = ct_mem[n] ^ 8'(ks[n]);
      checks++;
      if (rec !== orig[n]) begin
        errors++; $display("FAIL rt_pt[%0d] got %02h want %02h", n, rec, orig[n]);
      end
    end
  endtask

  task automatic test_zero_length();
    int cyc, bad;
    fill_pt(0, 1'b0);
    clear_ct();
    start_run(24'($urandom));
    wait_done("zero_len", 700, cyc);
    checks++; if (cyc > 520) begin errors++; $display("FAIL zero_latency got %0d cycles want <= 520", cyc); end
    checks++; if (wr_count != 1) begin errors++; $display("FAIL zero_writes got %0d want 1", wr_count); end
    checks++; if (ct_mem[0] !== 8'h00) begin errors++; $display("FAIL zero_ct0 got %02h want 00", ct_mem[0]); end
    bad = 0;
    for (int a = 1; a < 256; a++) if (ct_mem[a] !== fill_byte(a)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_untouched got %0d changed bytes want 0", bad); end
  endtask

  task automatic test_max_length();
    logic [23:0] kk;
    int cyc;
    kk = 24'($urandom);
    fill_pt(255, 1'b1);
    clear_ct();
    start_run(kk);
    wait_done("max_len", 1500, cyc);
    build_expected(kk, 255);
    for (int n = 0; n < 256; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL max_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
    checks++; if (wr_count != 256) begin errors++; $display("FAIL max_writes got %0d want 256", wr_count); end
    checks++; if (wr0_count != 1) begin errors++; $display("FAIL max_addr0_writes got %0d want 1", wr0_count); end
  endtask

  task automatic test_en_held();
    logic [23:0] kk;
    int cyc, runs, hi_len, snap;
    logic prev;
    kk = 24'($urandom);
    fill_pt(2, 1'b0);
    clear_ct();
    @(negedge clk);
    key = kk;
    en  = 1'b1;
    runs = 0; hi_len = 0; cyc = 0; prev = 1'b1;
    while (runs < 2 && cyc < 1400) begin
      @(negedge clk);
      cyc++;
      if (rdy && !prev) runs++;
      if (rdy && runs == 1) hi_len++;
      prev = rdy;
    end
    en = 1'b0;
    checks++; if (runs != 2) begin errors++; $display("FAIL held_runs got %0d want 2", runs); end
    checks++; if (hi_len != 1) begin errors++; $display("FAIL held_idle_window got %0d cycles want 1", hi_len); end
    checks++; if (wr_count != 6) begin errors++; $display("FAIL held_writes got %0d want 6", wr_count); end
    checks++; if (wr0_count != 2) begin errors++; $display("FAIL held_addr0_writes got %0d want 2", wr0_count); end
    snap = wr_count;
    repeat (6) @(negedge clk);
    checks++; if (rdy !== 1'b1 || wr_count != snap) begin
      errors++; $display("FAIL held_stop got rdy=%b writes=%0d want rdy=1 writes=%0d", rdy, wr_count, snap);
    end
    build_expected(kk, 2);
    for (int n = 0; n <= 2; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL held_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_en_busy();
    logic [23:0] kk;
    int cyc;
    kk = 24'($urandom);
    fill_pt(12, 1'b0);
    clear_ct();
    start_run(kk);
    repeat (5) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    repeat (300) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    repeat (220) @(negedge clk);
    en = 1'b1; @(negedge clk); en = 1'b0;
    wait_done("en_busy", 700, cyc);
    repeat (6) @(negedge clk);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL busy_no_restart got rdy=%b want 1", rdy); end
    checks++; if (wr_count != 13) begin errors++; $display("FAIL busy_writes got %0d want 13", wr_count); end
    build_expected(kk, 12);
    for (int n = 0; n <= 12; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL busy_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_key_change();
    logic [23:0] kk;
    int cyc;
    kk = 24'($urandom);
    fill_pt(16, 1'b0);
    clear_ct();
    start_run(kk);
    key = ~kk;
    repeat (300) @(negedge clk);
    key = 24'($urandom);
    wait_done("key_change", 700, cyc);
    build_expected(kk, 16);
    for (int n = 0; n <= 16; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL keychg_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] kk;
    int cyc, snap;
    kk = 24'($urandom);
    fill_pt(20, 1'b0);
    build_expected(kk, 20);
    clear_ct();
    start_run(kk);
    cyc = 0;
    while (!(ct_wren === 1'b1 && ct_addr == 8'd5) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL arst_reach_byte5 got no write to 5 in %0d cycles", cyc); end
    #2 rst = 1'b1;
    #1;
    snap = wr_count;
    checks++; if (rdy !== 1'b1)     begin errors++; $display("FAIL arst_rdy got %b want 1", rdy); end
    checks++; if (ct_wren !== 1'b0) begin errors++; $display("FAIL arst_wren got %b want 0", ct_wren); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (wr_count != snap) begin errors++; $display("FAIL arst_no_writes got %0d want %0d", wr_count, snap); end
    for (int n = 1; n <= 4; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL arst_partial_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
    clear_ct();
    start_run(kk);
    wait_done("arst_rerun", 700, cyc);
    checks++; if (wr_count != 21) begin errors++; $display("FAIL arst_rerun_writes got %0d want 21", wr_count); end
    for (int n = 0; n <= 20; n++) begin
      checks++;
      if (ct_mem[n] !== exp_ct[n]) begin
        errors++; $display("FAIL arst_rerun_ct[%0d] got %02h want %02h", n, ct_mem[n], exp_ct[n]);
      end
    end
  endtask

  task automatic test_addr_bounds();
    checks++;
    if (wr_bad != 0) begin errors++; $display("FAIL addr_bound got %0d writes above L want 0", wr_bad); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'h00;
    test_reset();
    test_known_vector();
    test_addr_bounds();
    test_round_trip();
    test_addr_bounds();
    test_zero_length();
    test_addr_bounds();
    test_max_length();
    test_en_held();
    test_addr_bounds();
    test_en_busy();
    test_addr_bounds();
    test_key_change();
    test_addr_bounds();
    test_async_reset();
    test_addr_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
